// File: rtl/jtkiwi_snd_pkg.sv
// Shared constants and helpers for the Kiwi sound-CPU bus decoder.
// Region nibbles are A[15:12] of the Z80 memory map.
package jtkiwi_snd_pkg;

  localparam logic [3:0] ROM_TOP = 4'hA;
  localparam logic [3:0] BANK_RG = 4'hA;
  localparam logic [3:0] FM_RG   = 4'hB;
  localparam logic [3:0] CAB_RG  = 4'hC;
  localparam logic [3:0] RAM_RG0 = 4'hD;
  localparam logic [3:0] RAM_RG1 = 4'hE;

  localparam int unsigned WAIT_W = 4;

  typedef enum logic [2:0] {
    RgNone,
    RgRom,
    RgBank,
    RgFm,
    RgCab,
    RgRam
  } region_e;

  function automatic region_e decode_region(input logic [3:0] nib);
    region_e rg;
    if (nib < ROM_TOP) begin
      rg = RgRom;
    end else begin
      case (nib)
        BANK_RG:          rg = RgBank;
        FM_RG:            rg = RgFm;
        CAB_RG:           rg = RgCab;
        RAM_RG0, RAM_RG1: rg = RgRam;
        default:          rg = RgNone;
      endcase
    end
    return rg;
  endfunction

  // Banked window: {1, bank, A[12:0]}; lower 32kB maps straight through.
  // Result is wide enough for bank widths up to 8; callers truncate.
  function automatic logic [22:0] banked_addr(input logic [15:0] a, input logic [7:0] bank,
                                              input int unsigned bankw);
    logic [22:0] r;
    if (a[15]) begin
      r = (23'd1 << (13 + bankw)) | ({15'd0, bank} << 13) | {10'd0, a[12:0]};
    end else begin
      r = {8'd0, a[14:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/jtkiwi_sndbus_wait.sv
// Wait generator for a slow device plus a shared-memory contention input.
// A new access (rising edge of dev_cs at cen) holds dev_busy for WAIT cen cycles.
module jtkiwi_sndbus_wait
  import jtkiwi_snd_pkg::*;
#(
  parameter int unsigned WAIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  input  logic dev_cs,
  input  logic shr_cs,
  input  logic shr_busy,
  output logic dev_busy
);

  logic [WAIT_W-1:0] cnt;
  logic              cs_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      cs_l <= 1'b0;
    end else if (cen) begin
      cs_l <= dev_cs;
      if (dev_cs && !cs_l) begin
        cnt <= WAIT_W'(WAIT);
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Gated by rst so an abandoned bus cycle releases the CPU immediately.
  assign dev_busy = ~rst & ((shr_cs & shr_busy) | (cnt != '0));

endmodule

// File: rtl/jtkiwi_sndbus.sv
// Sound-CPU bus controller: memory-map decode, ROM banking, device wait and VBLANK IRQ.
// Optional frame watchdog enabled with `define JTKIWI_WDOG_EN.
module jtkiwi_sndbus
  import jtkiwi_snd_pkg::*;
#(
  parameter int unsigned BANKW       = 2,
  parameter int unsigned FM_WAIT     = 1,
  parameter int unsigned WDOG_FRAMES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              snd_rstn,
  input  logic              LVBL,
  input  logic [15:0]       A,
  input  logic [7:0]        dout,
  input  logic              mreq_n,
  input  logic              rfsh_n,
  input  logic              iorq_n,
  input  logic              wr_n,
  input  logic              mshramen,
  input  logic [7:0]        rom_data,
  input  logic [7:0]        ram_dout,
  input  logic [7:0]        fm_dout,
  input  logic [7:0]        cab_dout,
  output logic [14+BANKW:0] rom_addr,
  output logic              rom_cs,
  output logic              bank_cs,
  output logic              fm_cs,
  output logic              cab_cs,
  output logic              ram_cs,
  output logic [7:0]        din,
  output logic              dev_busy,
  output logic              int_n,
  output logic [BANKW-1:0]  bank,
  output logic              mcu_rst,
  output logic              comb_rstn
);

  logic    rst_all;
  logic    mem_acc;
  region_e rg;
  logic    lvbl_l;
  logic    lvbl_fall;
  logic    wdog_rst;
  logic    wdog_hold;
  logic [7:0]  bank_ext;
  logic [22:0] addr_full;

  assign rst_all   = rst | ~comb_rstn;
  assign mem_acc   = ~mreq_n & rfsh_n;
  assign rg        = decode_region(A[15:12]);
  assign lvbl_fall = lvbl_l & ~LVBL;

  always_comb begin
    bank_ext              = '0;
    bank_ext[BANKW-1:0]   = bank;
    addr_full             = banked_addr(A, bank_ext, BANKW);
    rom_addr              = addr_full[14+BANKW:0];
  end

  if (BANKW < 7) begin : g_unused_dout
    logic unused_dout;
    assign unused_dout = ^dout[7:BANKW+1];
  end

  logic unused_addr;
  assign unused_addr = ^addr_full;

  always_ff @(posedge clk) begin
    comb_rstn <= snd_rstn & ~rst & ~wdog_hold;
  end

  always_ff @(posedge clk) begin
    if (rst_all) begin
      rom_cs  <= 1'b0;
      bank_cs <= 1'b0;
      fm_cs   <= 1'b0;
      cab_cs  <= 1'b0;
      ram_cs  <= 1'b0;
    end else begin
      rom_cs  <= mem_acc && (rg == RgRom);
      bank_cs <= mem_acc && (rg == RgBank);
      fm_cs   <= mem_acc && (rg == RgFm);
      cab_cs  <= mem_acc && (rg == RgCab);
      ram_cs  <= mem_acc && (rg == RgRam);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_all) begin
      din <= 8'h00;
    end else if (rom_cs) begin
      din <= rom_data;
    end else if (ram_cs) begin
      din <= ram_dout;
    end else if (fm_cs) begin
      din <= fm_dout;
    end else if (cab_cs) begin
      din <= cab_dout;
    end else begin
      din <= 8'h00;
    end
  end

  // Only qualified writes touch the bank; reads of the bank region are harmless.
  always_ff @(posedge clk) begin
    if (rst_all) begin
      bank    <= '0;
      mcu_rst <= 1'b0;
    end else if (bank_cs && !wr_n && cen) begin
      {mcu_rst, bank} <= dout[BANKW:0];
    end
  end

  // Edge detector runs through reset so a frame edge at release is not invented.
  always_ff @(posedge clk) begin
    lvbl_l <= LVBL;
  end

  // Set has priority over acknowledge so a frame interrupt is never dropped.
  always_ff @(posedge clk) begin
    if (rst_all) begin
      int_n <= 1'b1;
    end else if (lvbl_fall) begin
      int_n <= 1'b0;
    end else if (!iorq_n) begin
      int_n <= 1'b1;
    end
  end

  jtkiwi_sndbus_wait #(
    .WAIT (FM_WAIT)
  ) u_wait (
    .clk      (clk),
    .rst      (rst_all),
    .cen      (cen),
    .dev_cs   (fm_cs),
    .shr_cs   (ram_cs),
    .shr_busy (mshramen),
    .dev_busy (dev_busy)
  );

`ifdef JTKIWI_WDOG_EN
  localparam int unsigned FCW = $clog2(WDOG_FRAMES + 1);

  logic [FCW-1:0] fcnt;
  logic [4:0]     pcnt;
  logic           wdog_tail;

  // Counts frames since the last bank access; only the external reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt      <= '0;
      pcnt      <= '0;
      wdog_tail <= 1'b0;
    end else begin
      wdog_tail <= wdog_rst;
      if (pcnt != '0) begin
        pcnt <= pcnt - 1'b1;
        if (pcnt == 5'd1) fcnt <= '0;
      end else if (fcnt == FCW'(WDOG_FRAMES)) begin
        pcnt <= 5'd16;
      end else if (bank_cs) begin
        fcnt <= '0;
      end else if (lvbl_fall) begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign wdog_rst  = pcnt != '0;
  assign wdog_hold = wdog_rst | wdog_tail;
`else
  assign wdog_rst  = 1'b0;
  assign wdog_hold = wdog_rst;
`endif

endmodule

// File: tb/tb_jtkiwi_sndbus.sv
// Bench for jtkiwi_sndbus: directed scenarios followed by a randomized decode phase.
module tb_jtkiwi_sndbus;

  localparam int unsigned BANKW = 3;

  logic        clk = 1'b0;
  logic        rst, cen, snd_rstn, LVBL;
  logic [15:0] A;
  logic [7:0]  dout;
  logic        mreq_n, rfsh_n, iorq_n, wr_n, mshramen;
  logic [7:0]  rom_data, ram_dout, fm_dout, cab_dout;
  logic [14+BANKW:0] rom_addr;
  logic        rom_cs, bank_cs, fm_cs, cab_cs, ram_cs;
  logic [7:0]  din;
  logic        dev_busy, int_n, mcu_rst, comb_rstn;
  logic [BANKW-1:0] bank;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  jtkiwi_sndbus #(
    .BANKW       (BANKW),
    .FM_WAIT     (3),
    .WDOG_FRAMES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .snd_rstn  (snd_rstn),
    .LVBL      (LVBL),
    .A         (A),
    .dout      (dout),
    .mreq_n    (mreq_n),
    .rfsh_n    (rfsh_n),
    .iorq_n    (iorq_n),
    .wr_n      (wr_n),
    .mshramen  (mshramen),
    .rom_data  (rom_data),
    .ram_dout  (ram_dout),
    .fm_dout   (fm_dout),
    .cab_dout  (cab_dout),
    .rom_addr  (rom_addr),
    .rom_cs    (rom_cs),
    .bank_cs   (bank_cs),
    .fm_cs     (fm_cs),
    .cab_cs    (cab_cs),
    .ram_cs    (ram_cs),
    .din       (din),
    .dev_busy  (dev_busy),
    .int_n     (int_n),
    .bank      (bank),
    .mcu_rst   (mcu_rst),
    .comb_rstn (comb_rstn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cen_tick();
    cen = 1'b1;
    tick();
    cen = 1'b0;
    tick();
  endtask

  task automatic frame();
    LVBL = 1'b0;
    tick();
    LVBL = 1'b1;
    tick();
  endtask

  task automatic bank_write(input logic [7:0] val);
    A = 16'hA000; mreq_n = 1'b0; wr_n = 1'b0; dout = val; cen = 1'b1;
    tick();
    tick();
    mreq_n = 1'b1; wr_n = 1'b1; cen = 1'b0;
    tick();
  endtask

  // Reference region codes: 0 none, 1 rom, 2 bank, 3 fm, 4 cab, 5 ram.
  function automatic int region(input logic [15:0] a);
    if (a < 16'hA000) return 1;
    if (a < 16'hB000) return 2;
    if (a < 16'hC000) return 3;
    if (a < 16'hD000) return 4;
    if (a < 16'hF000) return 5;
    return 0;
  endfunction

  function automatic logic [4:0] selvec(input int s);
    logic [4:0] v;
    v = 5'b0;
    if (s == 1) v = 5'b10000;
    if (s == 2) v = 5'b01000;
    if (s == 3) v = 5'b00100;
    if (s == 4) v = 5'b00010;
    if (s == 5) v = 5'b00001;
    return v;
  endfunction

  function automatic logic [31:0] exp_rom_addr(input logic [15:0] a, input int b);
    if (a >= 16'h8000) return 32'h10000 + b * 32'h2000 + (a % 32'h2000);
    return a % 32'h8000;
  endfunction

  initial begin
    int low;
    int m_sel, m_bank, m_mcu, n_sel;
    logic [7:0] m_din;

    rst = 1'b1; cen = 1'b0; snd_rstn = 1'b1; LVBL = 1'b1; A = 16'h0000; dout = 8'h00;
    mreq_n = 1'b1; rfsh_n = 1'b1; iorq_n = 1'b1; wr_n = 1'b1; mshramen = 1'b0;
    rom_data = 8'h44; ram_dout = 8'h77; fm_dout = 8'h66; cab_dout = 8'h55;
    repeat (3) tick();
    chk("rst_sel", {rom_cs, bank_cs, fm_cs, cab_cs, ram_cs}, 0);
    chk("rst_din", din, 0);
    chk("rst_bank", {mcu_rst, bank}, 0);
    chk("rst_int_n", int_n, 1);
    chk("rst_busy", dev_busy, 0);
    chk("rst_comb_rstn", comb_rstn, 0);
    rst = 1'b0;
    tick();
    chk("comb_rstn_release", comb_rstn, 1);

    // Bank write then banked ROM read
    A = 16'hA000; mreq_n = 1'b0; wr_n = 1'b0; dout = 8'h0D;
    tick();
    chk("bank_cs", bank_cs, 1);
    cen = 1'b1;
    tick();
    cen = 1'b0; wr_n = 1'b1; mreq_n = 1'b1;
    chk("bank_wr", bank, 5);
    chk("mcu_rst_wr", mcu_rst, 1);
    tick();
    chk("bank_cs_idle", bank_cs, 0);
    A = 16'h8123; mreq_n = 1'b0; rom_data = 8'h5A;
    #1;
    chk("rom_cs_before", rom_cs, 0);
    tick();
    chk("rom_cs_after", rom_cs, 1);
    chk("rom_addr_banked", rom_addr, 32'h1A123);
    tick();
    chk("din_rom", din, 8'h5A);
    A = 16'h1234;
    tick();
    chk("rom_addr_low", rom_addr, 32'h1234);

    // Bank cleared by write, untouched by read; 0xF region is silent
    A = 16'hA000; wr_n = 1'b0; dout = 8'h00; cen = 1'b1;
    tick();
    tick();
    chk("bank_clear", {mcu_rst, bank}, 0);
    wr_n = 1'b1; dout = 8'h03;
    tick();
    tick();
    cen = 1'b0;
    chk("bank_read_keep", {mcu_rst, bank}, 0);
    A = 16'hF000;
    tick();
    chk("sel_f_region", {rom_cs, bank_cs, fm_cs, cab_cs, ram_cs}, 0);
    tick();
    chk("din_f_region", din, 0);

    // FM wait: three cen cycles per new access
    mreq_n = 1'b1;
    tick();
    A = 16'hB000; mreq_n = 1'b0;
    tick();
    chk("fm_cs", fm_cs, 1);
    chk("fm_busy_pre", dev_busy, 0);
    for (int k = 1; k <= 6; k++) begin
      cen_tick();
      chk($sformatf("fm_busy_hold_%0d", k), dev_busy, (k <= 3) ? 1 : 0);
    end
    chk("din_fm", din, 8'h66);
    mreq_n = 1'b1;
    cen_tick();
    cen_tick();
    chk("fm_cs_drop", fm_cs, 0);
    mreq_n = 1'b0;
    tick();
    for (int k = 1; k <= 4; k++) begin
      cen_tick();
      chk($sformatf("fm_busy_again_%0d", k), dev_busy, (k <= 3) ? 1 : 0);
    end

    // Reset in the middle of an FM wait
    mreq_n = 1'b1;
    cen_tick();
    cen_tick();
    mreq_n = 1'b0;
    tick();
    cen_tick();
    chk("fm_busy_pre_rst", dev_busy, 1);
    rst = 1'b1;
    #1;
    chk("busy_drop_on_rst", dev_busy, 0);
    mreq_n = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("busy_after_rst", dev_busy, 0);
    chk("fm_cs_after_rst", fm_cs, 0);

    // Shared RAM contention and cabinet read
    A = 16'hD000; mreq_n = 1'b0; mshramen = 1'b1;
    tick();
    chk("ram_cs_d", ram_cs, 1);
    chk("ram_busy", dev_busy, 1);
    mshramen = 1'b0;
    #1;
    chk("ram_busy_drop", dev_busy, 0);
    tick();
    chk("din_ram", din, 8'h77);
    A = 16'hE000;
    tick();
    chk("ram_cs_e", ram_cs, 1);
    A = 16'hC000;
    tick();
    chk("cab_cs", cab_cs, 1);
    tick();
    chk("din_cab", din, 8'h55);
    mreq_n = 1'b1;
    tick();

    // VBLANK interrupt: set wins over a simultaneous acknowledge
    LVBL = 1'b0; iorq_n = 1'b0;
    tick();
    chk("irq_set_wins", int_n, 0);
    iorq_n = 1'b1;
    tick();
    chk("irq_held", int_n, 0);
    iorq_n = 1'b0;
    tick();
    chk("irq_ack", int_n, 1);
    iorq_n = 1'b1; LVBL = 1'b1;
    tick();

    snd_rstn = 1'b0;
    tick();
    chk("snd_rstn_low", comb_rstn, 0);
    snd_rstn = 1'b1;
    tick();
    chk("snd_rstn_high", comb_rstn, 1);

    // Watchdog: two silent frames, then two frames with a bank access between
    bank_write(8'h03);
    chk("bank_pre_wdog", bank, 3);
    frame();
    frame();
    low = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!comb_rstn) low++;
    end
`ifdef JTKIWI_WDOG_EN
    chk("wdog_low_cycles", low, 17);
    chk("wdog_bank", bank, 0);
`else
    chk("wdog_low_cycles", low, 0);
    chk("wdog_bank", bank, 3);
`endif
    chk("wdog_comb_rstn_end", comb_rstn, 1);
    bank_write(8'h03);
    frame();
    A = 16'hA000; mreq_n = 1'b0;
    tick();
    mreq_n = 1'b1;
    tick();
    frame();
    low = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!comb_rstn) low++;
    end
    chk("wdog_kicked_low", low, 0);
    chk("wdog_kicked_bank", bank, 3);

    // Randomized decode / banking / read-mux phase against the model
    bank_write(8'h06);
    m_sel = 0; m_bank = 6; m_mcu = 0; m_din = 8'h00;
    for (int i = 0; i < 300; i++) begin
      A        = 16'($urandom);
      mreq_n   = ($urandom_range(0, 3) == 0);
      rfsh_n   = ($urandom_range(0, 7) != 0);
      wr_n     = 1'($urandom);
      cen      = 1'($urandom);
      dout     = 8'($urandom);
      rom_data = 8'($urandom);
      ram_dout = 8'($urandom);
      fm_dout  = 8'($urandom);
      cab_dout = 8'($urandom);
      case (m_sel)
        1:       m_din = rom_data;
        3:       m_din = fm_dout;
        4:       m_din = cab_dout;
        5:       m_din = ram_dout;
        default: m_din = 8'h00;
      endcase
      if (m_sel == 2 && !wr_n && cen) begin
        m_bank = dout % 8;
        m_mcu  = (dout / 8) % 2;
      end
      n_sel = (!mreq_n && rfsh_n) ? region(A) : 0;
      m_sel = n_sel;
      tick();
      chk("rnd_sel", {rom_cs, bank_cs, fm_cs, cab_cs, ram_cs}, selvec(m_sel));
      chk("rnd_din", din, m_din);
      chk("rnd_bank", bank, m_bank);
      chk("rnd_mcu_rst", mcu_rst, m_mcu);
      chk("rnd_rom_addr", rom_addr, exp_rom_addr(A, m_bank));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
